// File: rtl/input_port_writer.sv
// input_port_writer: port-A write side of the pixel double buffer.
// Packs the {R,G,B} pixel stream into 32-bit words per colour and writes
// them into the BANK_COUNT x BLOCK_COUNT BRAM grid. All outputs except
// O_ready are registered (one cycle after the pixel that caused them).
//
// Handshake: a pixel is transferred on a rising edge where I_valid && O_ready.
// O_ready depends only on the current state, never on I_valid. A pixel
// offered while O_ready is low (or a non-SOF pixel while idle) is not
// stored and is reported by a one-cycle O_drop pulse on the next cycle.
module input_port_writer #(
  parameter int BYTES_PER_BLOCK    = 2250,
  parameter int BANK_COUNT         = 6,
  parameter int BLOCK_COUNT        = 2,
  parameter int BLOCK_DATA_WIDTH_A = 32,
  parameter int ADDRESS_NUMBER_A   =
    (BYTES_PER_BLOCK * 8 + BLOCK_DATA_WIDTH_A - 1) / BLOCK_DATA_WIDTH_A,
  parameter int AW                 = $clog2(ADDRESS_NUMBER_A)
) (
  input  logic                                               I_clka,
  input  logic                                               I_rst,
  input  logic                                               I_sof,
  input  logic                                               I_eof,
  input  logic                                               I_valid,
  output logic                                               O_ready,
  input  logic [23:0]                                        I_pixel,
  output logic [AW-1:0]                                      O_addresses_common,
  output logic [BANK_COUNT*BLOCK_COUNT*BLOCK_DATA_WIDTH_A-1:0] O_data_flat,
  output logic [BANK_COUNT*BLOCK_COUNT-1:0]                  O_wea,
  output logic                                               O_frame_done,
  output logic                                               O_drop,
  output logic [1:0]                                         O_dbg_state
);

  localparam int NSLICE = BANK_COUNT * BLOCK_COUNT;
  localparam int WW     = BLOCK_DATA_WIDTH_A;
  localparam int DW     = NSLICE * WW;
  localparam logic [AW-1:0] ADDR_LAST = AW'(ADDRESS_NUMBER_A - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Frame state
  state_t                 state_q, state_d;
  logic [2:0]             byte_cnt_q, byte_cnt_d;
  logic                   half_q, half_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [2:0][WW-1:0]     pack_q, pack_d;

  // Registered write-port outputs
  logic [NSLICE-1:0]      wea_q, wea_d;
  logic [DW-1:0]          data_q, data_d;
  logic [AW-1:0]          addr_out_q, addr_out_d;
  logic                   done_q, done_d;
  logic                   drop_q, drop_d;

  // Per-cycle write request and pixel-processing helpers
  logic                   ready;
  logic                   take_pix;
  logic                   start;
  logic                   full;
  logic [2:0]             cnt_v;
  logic [AW-1:0]          addr_v;
  logic                   half_v;
  logic [1:0]             k;
  logic                   wr_en;
  logic                   wr_blk;
  logic                   wr_half;
  logic [AW-1:0]          wr_addr;
  logic [2:0][WW-1:0]     wr_word;

  assign ready              = (state_q == S_IDLE) || (state_q == S_FILL);
  assign O_ready            = ready;
  assign O_wea              = wea_q;
  assign O_data_flat        = data_q;
  assign O_addresses_common = addr_out_q;
  assign O_frame_done       = done_q;
  assign O_drop             = drop_q;
  assign O_dbg_state        = state_q;

  // Next-state, packing and write-request logic
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    half_d     = half_q;
    addr_d     = addr_q;
    pack_d     = pack_q;
    drop_d     = 1'b0;
    done_d     = 1'b0;
    take_pix   = 1'b0;
    start      = 1'b0;
    full       = 1'b0;
    cnt_v      = byte_cnt_q;
    addr_v     = addr_q;
    half_v     = half_q;
    k          = byte_cnt_q[1:0];
    wr_en      = 1'b0;
    wr_blk     = 1'b0;
    wr_half    = half_q;
    wr_addr    = addr_q;
    wr_word    = pack_q;

    case (state_q)
      S_IDLE: begin
        if (I_valid) begin
          if (I_sof) begin
            take_pix = 1'b1;
            start    = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (I_valid) begin
          take_pix = 1'b1;
          start    = I_sof;
        end else if (I_eof) begin
          state_d = (byte_cnt_q == 3'd0) ? S_DONE : S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Partial word already zero-padded: bytes above the last one were
        // cleared when the word was started.
        drop_d  = I_valid;
        wr_en   = 1'b1;
        wr_blk  = (byte_cnt_q > 3'd4);
        wr_word = pack_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        drop_d  = I_valid;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take_pix) begin
      // A SOF pixel restarts the frame: byte 0 at address 0, half 0.
      cnt_v   = start ? 3'd0 : byte_cnt_q;
      addr_v  = start ? '0 : addr_q;
      half_v  = start ? 1'b0 : half_q;
      k       = cnt_v[1:0];
      state_d = S_FILL;
      for (int c = 0; c < 3; c++) begin
        if (k == 2'd0) pack_d[c] = '0;
        else           pack_d[c] = pack_q[c];
        pack_d[c][{k, 3'b000} +: 8] = I_pixel[23 - 8 * c -: 8];
      end
      byte_cnt_d = cnt_v + 3'd1;
      addr_d     = addr_v;
      half_d     = half_v;
      if (k == 2'd3) begin
        wr_en   = 1'b1;
        wr_blk  = cnt_v[2];
        wr_word = pack_d;
        wr_addr = addr_v;
        wr_half = half_v;
        if (cnt_v[2]) begin
          if (addr_v == ADDR_LAST) begin
            addr_d = '0;
            if (half_v) full = 1'b1;
            else        half_d = 1'b1;
          end else begin
            addr_d = addr_v + AW'(1);
          end
        end
      end
      if (full) begin
        state_d    = S_DONE;
        half_d     = 1'b0;
        byte_cnt_d = 3'd0;
      end else if (I_eof) begin
        state_d = (byte_cnt_d == 3'd0) ? S_DONE : S_FLUSH;
      end
    end
  end

  // Fan the write request out to the three colour banks of the active half
  always_comb begin
    wea_d      = '0;
    data_d     = '0;
    addr_out_d = wr_en ? wr_addr : addr_d;
    if (wr_en) begin
      for (int c = 0; c < 3; c++) begin
        wea_d[(c * 2 + int'(wr_half)) * BLOCK_COUNT + int'(wr_blk)] = 1'b1;
        data_d[((c * 2 + int'(wr_half)) * BLOCK_COUNT + int'(wr_blk)) * WW +: WW] = wr_word[c];
      end
    end
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge I_clka) begin
    if (I_rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 3'd0;
      half_q     <= 1'b0;
      addr_q     <= '0;
      pack_q     <= '0;
      wea_q      <= '0;
      data_q     <= '0;
      addr_out_q <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      half_q     <= half_d;
      addr_q     <= addr_d;
      pack_q     <= pack_d;
      wea_q      <= wea_d;
      data_q     <= data_d;
      addr_out_q <= addr_out_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_input_port_writer.sv
// Bench for input_port_writer: a byte-position reference model pushes the
// expected writes into exp_q; a monitor pops and compares on every DUT write.
module tb_input_port_writer;

  localparam int AN = 563;
  localparam int AW = 10;
  localparam int NS = 12;
  localparam int DW = NS * 32;
  localparam int EW = 2 + AW + 96;
  localparam int FULL_BYTES = 2 * AN * 8;

  logic          clk = 1'b0;
  logic          I_rst, I_sof, I_eof, I_valid;
  logic [23:0]   I_pixel;
  logic          O_ready, O_frame_done, O_drop;
  logic [AW-1:0] O_addresses_common;
  logic [DW-1:0] O_data_flat;
  logic [NS-1:0] O_wea;
  logic [1:0]    O_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // expected entry: {half, block, addr, R word, G word, B word}
  logic [EW-1:0] exp_q[$];

  bit          m_active = 1'b0;
  int          m_n      = 0;
  int          m_busy   = 0;
  logic [31:0] m_w[3];
  int          exp_drops = 0, obs_drops = 0;
  int          exp_dones = 0, obs_dones = 0;

  input_port_writer dut (
    .I_clka             (clk),
    .I_rst              (I_rst),
    .I_sof              (I_sof),
    .I_eof              (I_eof),
    .I_valid            (I_valid),
    .O_ready            (O_ready),
    .I_pixel            (I_pixel),
    .O_addresses_common (O_addresses_common),
    .O_data_flat        (O_data_flat),
    .O_wea              (O_wea),
    .O_frame_done       (O_frame_done),
    .O_drop             (O_drop),
    .O_dbg_state        (O_dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte n of a frame belongs to word n/4; that word's
  // block is its parity, its address (n/8) mod AN and its half (n/8)/AN.
  task automatic model_step(input bit v, input bit sof, input bit eof, input logic [23:0] pix);
    int k, widx, cnt, pair;
    if (m_busy > 0) begin
      if (v) exp_drops++;
      m_busy--;
      return;
    end
    if (v) begin
      if (sof) begin
        m_active = 1'b1;
        m_n      = 0;
      end
      if (!m_active) begin
        exp_drops++;
      end else begin
        k = m_n % 4;
        if (k == 0) for (int c = 0; c < 3; c++) m_w[c] = '0;
        for (int c = 0; c < 3; c++) m_w[c][8 * k +: 8] = pix[23 - 8 * c -: 8];
        if (k == 3) begin
          widx = m_n / 4;
          exp_q.push_back({1'(widx / (2 * AN)), 1'(widx % 2), AW'((widx / 2) % AN),
                           m_w[0], m_w[1], m_w[2]});
        end
        m_n++;
        if (m_n == FULL_BYTES) begin
          m_active = 1'b0;
          m_busy   = 1;
          exp_dones++;
          return;
        end
      end
    end
    if (eof && m_active) begin
      cnt = m_n % 8;
      if (cnt == 0) begin
        m_busy = 1;
      end else begin
        pair = m_n / 8;
        exp_q.push_back({1'(pair / AN), 1'(cnt > 4), AW'(pair % AN), m_w[0], m_w[1], m_w[2]});
        m_busy = 2;
      end
      m_active = 1'b0;
      exp_dones++;
    end
  endtask

  // driver: present one cycle of inputs, outputs of that edge visible on return
  task automatic drive(input bit v, input bit sof, input bit eof, input logic [23:0] pix);
    I_valid = v;
    I_sof   = sof;
    I_eof   = eof;
    I_pixel = pix;
    model_step(v, sof, eof, pix);
    @(posedge clk);
    #1;
    I_valid = 1'b0;
    I_sof   = 1'b0;
    I_eof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic do_reset();
    I_rst = 1'b1;
    @(posedge clk);
    #1;
    I_rst    = 1'b0;
    m_active = 1'b0;
    m_busy   = 0;
    m_n      = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wea"},   O_wea, 0);
    check_eq({tag, "_data"},  {127'h0, (O_data_flat != '0)}, 0);
    check_eq({tag, "_addr"},  O_addresses_common, 0);
    check_eq({tag, "_done"},  O_frame_done, 0);
    check_eq({tag, "_drop"},  O_drop, 0);
    check_eq({tag, "_ready"}, O_ready, 1);
    check_eq({tag, "_state"}, O_dbg_state, 0);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_drops"}, obs_drops, exp_drops);
    check_eq({tag, "_dones"}, obs_dones, exp_dones);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [NS-1:0] ew;
    logic [DW-1:0] mask;
    int            off;
    if (!I_rst) begin
      if (O_drop) obs_drops++;
      if (O_frame_done) obs_dones++;
      if (O_wea != '0) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", O_wea, 0);
        end else begin
          e    = exp_q.pop_front();
          off  = int'(e[EW-1 -: 2]);
          ew   = '0;
          mask = '0;
          for (int c = 0; c < 3; c++) begin
            ew[4 * c + off] = 1'b1;
            mask[(4 * c + off) * 32 +: 32] = '1;
          end
          check_eq("wr_wea",  O_wea, ew);
          check_eq("wr_addr", O_addresses_common, e[96 +: AW]);
          for (int c = 0; c < 3; c++)
            check_eq("wr_data", O_data_flat[(4 * c + off) * 32 +: 32], e[64 - 32 * c +: 32]);
          check_eq("wr_idle_slices_zero", {127'h0, ((O_data_flat & ~mask) != '0)}, 0);
        end
      end
    end
  end

  initial begin
    I_rst   = 1'b1;
    I_sof   = 1'b0;
    I_eof   = 1'b0;
    I_valid = 1'b0;
    I_pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    I_rst = 1'b0;
    check_reset_outputs("reset");

    // 1: eight bytes with known values
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, 1'b0, {8'(i), 8'(16 + i), 8'(32 + i)});
      if (i == 3) begin
        check_eq("t1_wea_b0",  O_wea, 12'h111);
        check_eq("t1_slice0",  O_data_flat[31:0], 32'h03020100);
        check_eq("t1_addr_b0", O_addresses_common, 0);
      end
      if (i == 7) begin
        check_eq("t1_wea_b1",  O_wea, 12'h222);
        check_eq("t1_slice1",  O_data_flat[63:32], 32'h07060504);
        check_eq("t1_addr_b1", O_addresses_common, 0);
      end
    end
    idle(1);
    check_eq("t1_addr_next", O_addresses_common, 1);
    drive(1'b0, 1'b0, 1'b1, 24'h0);
    idle(3);
    check_counts("t1");

    // 2: fill both halves completely
    for (int i = 0; i < FULL_BYTES; i++) begin
      drive(1'b1, i == 0, 1'b0, 24'($urandom));
      if (i == FULL_BYTES - 1) begin
        check_eq("t2_last_wea",   O_wea, 12'h888);
        check_eq("t2_last_addr",  O_addresses_common, AN - 1);
        check_eq("t2_ready_done", O_ready, 0);
      end
    end
    idle(1);
    check_eq("t2_frame_done", O_frame_done, 1);
    check_eq("t2_ready_back", O_ready, 1);
    idle(1);
    check_eq("t2_done_pulse", O_frame_done, 0);
    idle(2);
    check_counts("t2");

    // 3: five bytes then EOF alone -> flush of block 1
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b0, 24'($urandom_range(0, 24'hFFFFFF)));
    drive(1'b0, 1'b0, 1'b1, 24'h0);
    check_eq("t3_ready_flush", O_ready, 0);
    idle(1);
    check_eq("t3_flush_wea",  O_wea, 12'h222);
    check_eq("t3_flush_pad",  O_data_flat[63:40], 0);
    check_eq("t3_done_early", O_frame_done, 0);
    idle(1);
    check_eq("t3_frame_done", O_frame_done, 1);
    idle(2);
    check_counts("t3");

    // 4: EOF with the eighth pixel
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, i == 7, 24'($urandom));
    check_eq("t4_wea",   O_wea, 12'h222);
    check_eq("t4_ready", O_ready, 0);
    idle(1);
    check_eq("t4_frame_done", O_frame_done, 1);
    idle(2);
    check_counts("t4");

    // 5: ten pixels, then SOF aborts and restarts
    for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 1'b0, 24'($urandom));
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 1'b0, {8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i)});
    drive(1'b0, 1'b0, 1'b1, 24'h0);
    idle(3);
    check_counts("t5");

    // 6: drops in IDLE, FLUSH and DONE; reset mid-frame
    drive(1'b1, 1'b0, 1'b0, 24'h123456);
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, i == 2, 24'($urandom));
    drive(1'b1, 1'b0, 1'b0, 24'h111111);
    drive(1'b1, 1'b1, 1'b0, 24'h222222);
    idle(2);
    for (int i = 0; i < 2; i++) drive(1'b1, i == 0, 1'b0, 24'($urandom));
    do_reset();
    check_reset_outputs("midreset");
    drive(1'b1, 1'b0, 1'b0, 24'h333333);
    idle(3);
    check_counts("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
